// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-master LSU arbiter: FSM states, request payload, master ID.
// The optional lock feature is enabled by defining LSU_ARB_LOCK_EN.
package lsu_arb_pkg;

  localparam int unsigned MAX_LOCK_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef logic mid_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        wren;
    logic        lock;
  } req_t;

  function automatic mid_t other_master(input mid_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/lsu_arb_rr.sv
// Combinational two-input round-robin pick with an optional lock override.
// Produces a one-hot grant; all zeros when neither master is valid.
module lsu_arb_rr
  import lsu_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  mid_t       rr_ptr,
  input  logic       lock_hold,
  input  mid_t       lock_id,
  output logic [1:0] grant
);

  // A live lock wins over the pointer; otherwise ties go to rr_ptr.
  always_comb begin
    grant = 2'b00;
    if (lock_hold && valid[lock_id]) begin
      grant[lock_id] = 1'b1;
    end else if (valid == 2'b11) begin
      grant[rr_ptr] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-master arbiter in front of a single-cycle LSU: accept, issue, respond.
// Define LSU_ARB_LOCK_EN to let a master hold the port for up to MAX_LOCK grants.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_valid,
  output logic        o_m0_ready,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_bmask,
  input  logic        i_m0_wren,
  input  logic        i_m0_lock,
  output logic        o_m0_rsp_valid,
  output logic [31:0] o_m0_rsp_rdata,
  input  logic        i_m1_valid,
  output logic        o_m1_ready,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_bmask,
  input  logic        i_m1_wren,
  input  logic        i_m1_lock,
  output logic        o_m1_rsp_valid,
  output logic [31:0] o_m1_rsp_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  output logic [3:0]  o_lsu_bmask,
  output logic        o_lsu_wren,
  input  logic [31:0] i_lsu_rdata
);

  state_t      state;
  mid_t        rr_ptr;
  mid_t        gid;
  mid_t        lock_id;
  logic        lock_hold;
  logic        accept;
  logic [1:0]  valid;
  logic [1:0]  grant;
  req_t        m_req [2];

  logic [31:0] iss_addr;
  logic [31:0] iss_wdata;
  logic [3:0]  iss_bmask;
  logic        iss_wren;
  mid_t        iss_id;

  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data [2];

  assign valid    = {i_m1_valid, i_m0_valid};
  assign m_req[0] = '{addr: i_m0_addr, wdata: i_m0_wdata, bmask: i_m0_bmask,
                      wren: i_m0_wren, lock: i_m0_lock};
  assign m_req[1] = '{addr: i_m1_addr, wdata: i_m1_wdata, bmask: i_m1_bmask,
                      wren: i_m1_wren, lock: i_m1_lock};

  // The last granted master is always the one rr_ptr does not point at.
  assign lock_id = other_master(rr_ptr);

`ifdef LSU_ARB_LOCK_EN
  logic [3:0] lock_cnt;

  assign lock_hold = (lock_cnt != 4'd0) && (lock_cnt < 4'(MAX_LOCK));

  // Counts consecutive locked grants; a fresh locked run starts at 1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lock_cnt <= 4'd0;
    end else if (accept) begin
      if (!m_req[gid].lock) begin
        lock_cnt <= 4'd0;
      end else if (lock_hold && (gid == lock_id)) begin
        lock_cnt <= lock_cnt + 4'd1;
      end else begin
        lock_cnt <= 4'd1;
      end
    end
  end
`else
  logic unused_lock;

  assign lock_hold   = 1'b0;
  assign unused_lock = m_req[0].lock ^ m_req[1].lock;
`endif

  lsu_arb_rr u_rr (
    .valid     (valid),
    .rr_ptr    (rr_ptr),
    .lock_hold (lock_hold),
    .lock_id   (lock_id),
    .grant     (grant)
  );

  assign accept     = (state != ISSUE) && !i_reset && (valid != 2'b00);
  assign gid        = mid_t'(grant[1]);
  assign o_m0_ready = accept && grant[0];
  assign o_m1_ready = accept && grant[1];

  // Single FSM: captures the winner, issues one LSU cycle, then returns the response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      iss_addr    <= '0;
      iss_wdata   <= '0;
      iss_bmask   <= '0;
      iss_wren    <= 1'b0;
      iss_id      <= 1'b0;
      rsp_valid   <= 2'b00;
      rsp_data[0] <= '0;
      rsp_data[1] <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          rsp_valid <= 2'b00;
          if (accept) begin
            state     <= ISSUE;
            rr_ptr    <= other_master(gid);
            iss_addr  <= m_req[gid].addr;
            iss_wdata <= m_req[gid].wdata;
            iss_bmask <= m_req[gid].bmask;
            iss_wren  <= m_req[gid].wren;
            iss_id    <= gid;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state            <= RESP;
          rsp_valid        <= 2'b01 << iss_id;
          rsp_data[iss_id] <= iss_wren ? 32'd0 : i_lsu_rdata;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 2'b00;
        end
      endcase
    end
  end

  assign o_lsu_addr     = (state == ISSUE) ? iss_addr : 32'd0;
  assign o_lsu_wdata    = (state == ISSUE) ? iss_wdata : 32'd0;
  assign o_lsu_bmask    = (state == ISSUE) ? iss_bmask : 4'd0;
  assign o_lsu_wren     = (state == ISSUE) && !i_reset && iss_wren;

  assign o_m0_rsp_valid = rsp_valid[0];
  assign o_m1_rsp_valid = rsp_valid[1];
  assign o_m0_rsp_rdata = rsp_data[0];
  assign o_m1_rsp_rdata = rsp_data[1];

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: reset, single write, alternating reads, lock pattern,
// reset during issue and fairness; the LSU model returns addr + 0x100.
module tb_lsu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_valid, i_m1_valid;
  logic        o_m0_ready, o_m1_ready;
  logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
  logic [3:0]  i_m0_bmask, i_m1_bmask;
  logic        i_m0_wren, i_m0_lock, i_m1_wren, i_m1_lock;
  logic        o_m0_rsp_valid, o_m1_rsp_valid;
  logic [31:0] o_m0_rsp_rdata, o_m1_rsp_rdata;
  logic [31:0] o_lsu_addr, o_lsu_wdata, i_lsu_rdata;
  logic [3:0]  o_lsu_bmask;
  logic        o_lsu_wren;

  int tests    = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  assign i_lsu_rdata = o_lsu_addr + 32'h100;

  lsu_arbiter #(.MAX_LOCK(4)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_m0_valid     (i_m0_valid),
    .o_m0_ready     (o_m0_ready),
    .i_m0_addr      (i_m0_addr),
    .i_m0_wdata     (i_m0_wdata),
    .i_m0_bmask     (i_m0_bmask),
    .i_m0_wren      (i_m0_wren),
    .i_m0_lock      (i_m0_lock),
    .o_m0_rsp_valid (o_m0_rsp_valid),
    .o_m0_rsp_rdata (o_m0_rsp_rdata),
    .i_m1_valid     (i_m1_valid),
    .o_m1_ready     (o_m1_ready),
    .i_m1_addr      (i_m1_addr),
    .i_m1_wdata     (i_m1_wdata),
    .i_m1_bmask     (i_m1_bmask),
    .i_m1_wren      (i_m1_wren),
    .i_m1_lock      (i_m1_lock),
    .o_m1_rsp_valid (o_m1_rsp_valid),
    .o_m1_rsp_rdata (o_m1_rsp_rdata),
    .o_lsu_addr     (o_lsu_addr),
    .o_lsu_wdata    (o_lsu_wdata),
    .o_lsu_bmask    (o_lsu_bmask),
    .o_lsu_wren     (o_lsu_wren),
    .i_lsu_rdata    (i_lsu_rdata)
  );

  task automatic nextCycle;
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic v1);
    i_m0_valid = v0;
    i_m1_valid = v1;
  endtask

  task automatic setM0(input logic [31:0] a, input logic [31:0] d, input logic w, input logic l);
    i_m0_addr = a; i_m0_wdata = d; i_m0_bmask = 4'hF; i_m0_wren = w; i_m0_lock = l;
  endtask

  task automatic setM1(input logic [31:0] a, input logic [31:0] d, input logic w, input logic l);
    i_m1_addr = a; i_m1_wdata = d; i_m1_bmask = 4'h3; i_m1_wren = w; i_m1_lock = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic doReset;
    applyStimulus(1'b0, 1'b0);
    i_reset = 1'b1;
    nextCycle();
    i_reset = 1'b0;
  endtask

  initial begin
    int   pat [9];
    int   exp_m;
    int   prev_m;
    int   slot;
    logic granted;

    i_reset = 1'b1;
    setM0(32'h1000_0000, 32'h0000_00A5, 1'b1, 1'b0);
    setM1(32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Reset state, with m0 already requesting
    nextCycle();
    @(negedge i_clk);
    checkBit("rst_ready0", o_m0_ready, 1'b0);
    checkBit("rst_rsp_valid0", o_m0_rsp_valid, 1'b0);
    checkBit("rst_rsp_valid1", o_m1_rsp_valid, 1'b0);
    checkOutput("rst_rdata0", o_m0_rsp_rdata, 32'h0);
    checkBit("rst_lsu_wren", o_lsu_wren, 1'b0);
    checkOutput("rst_lsu_addr", o_lsu_addr, 32'h0);

    // Single write from m0, accepted in the first cycle after reset
    nextCycle();
    i_reset = 1'b0;
    @(negedge i_clk);
    checkBit("wr_c0_ready0", o_m0_ready, 1'b1);
    checkBit("wr_c0_ready1", o_m1_ready, 1'b0);
    checkBit("wr_c0_lsu_wren", o_lsu_wren, 1'b0);
    nextCycle();
    @(negedge i_clk);
    checkBit("wr_c1_lsu_wren", o_lsu_wren, 1'b1);
    checkOutput("wr_c1_lsu_addr", o_lsu_addr, 32'h1000_0000);
    checkOutput("wr_c1_lsu_wdata", o_lsu_wdata, 32'h0000_00A5);
    checkOutput("wr_c1_lsu_bmask", {28'h0, o_lsu_bmask}, 32'hF);
    checkBit("wr_c1_ready0", o_m0_ready, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    @(negedge i_clk);
    checkBit("wr_c2_rsp_valid0", o_m0_rsp_valid, 1'b1);
    checkOutput("wr_c2_rdata0", o_m0_rsp_rdata, 32'h0);
    checkBit("wr_c2_rsp_valid1", o_m1_rsp_valid, 1'b0);
    checkBit("wr_c2_lsu_wren", o_lsu_wren, 1'b0);
    nextCycle();
    @(negedge i_clk);
    checkBit("wr_c3_rsp_valid0", o_m0_rsp_valid, 1'b0);

    // Both masters reading continuously: grants alternate m0, m1, m0, m1
    doReset();
    setM0(32'h04, 32'h0, 1'b0, 1'b0);
    setM1(32'h08, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int g = 0; g < 5; g++) begin
      exp_m = g % 2;
      @(negedge i_clk);
      if (g > 0) begin
        prev_m = (g - 1) % 2;
        checkBit("rr_rsp_valid0", o_m0_rsp_valid, prev_m == 0);
        checkBit("rr_rsp_valid1", o_m1_rsp_valid, prev_m == 1);
        if (prev_m == 0) checkOutput("rr_rdata0", o_m0_rsp_rdata, 32'h104);
        else             checkOutput("rr_rdata1", o_m1_rsp_rdata, 32'h108);
        if (g > 1) begin
          if (prev_m == 0) checkOutput("rr_hold_rdata1", o_m1_rsp_rdata, 32'h108);
          else             checkOutput("rr_hold_rdata0", o_m0_rsp_rdata, 32'h104);
        end
      end
      if (g < 4) begin
        checkBit("rr_ready0", o_m0_ready, exp_m == 0);
        checkBit("rr_ready1", o_m1_ready, exp_m == 1);
        nextCycle();
        @(negedge i_clk);
        checkOutput("rr_lsu_addr", o_lsu_addr, (exp_m == 0) ? 32'h04 : 32'h08);
        checkBit("rr_issue_ready0", o_m0_ready, 1'b0);
        checkBit("rr_issue_ready1", o_m1_ready, 1'b0);
        nextCycle();
      end
    end

    // m0 locked and m1 both always valid
`ifdef LSU_ARB_LOCK_EN
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
`else
    pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
    doReset();
    setM0(32'h10, 32'h0, 1'b0, 1'b1);
    setM1(32'h20, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int g = 0; g < 9; g++) begin
      @(negedge i_clk);
      checkBit("lock_ready0", o_m0_ready, pat[g] == 0);
      checkBit("lock_ready1", o_m1_ready, pat[g] == 1);
      nextCycle();
      nextCycle();
    end

    // Reset asserted while an m1 write is in ISSUE
    doReset();
    setM0(32'h30, 32'h0, 1'b0, 1'b0);
    setM1(32'h1000_0004, 32'h5A, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    @(negedge i_clk);
    checkBit("rst_iss_ready1", o_m1_ready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    i_reset = 1'b1;
    @(negedge i_clk);
    checkBit("rst_iss_lsu_wren", o_lsu_wren, 1'b0);
    nextCycle();
    i_reset = 1'b0;
    applyStimulus(1'b1, 1'b1);
    @(negedge i_clk);
    checkBit("rst_iss_rsp_valid1", o_m1_rsp_valid, 1'b0);
    checkOutput("rst_iss_rdata1", o_m1_rsp_rdata, 32'h0);
    checkBit("rst_iss_ready0", o_m0_ready, 1'b1);
    checkBit("rst_iss_ready1", o_m1_ready, 1'b0);

    // m1 joins while m0 streams: must win within two accept slots
    doReset();
    setM0(32'h40, 32'h0, 1'b0, 1'b0);
    setM1(32'h200, 32'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    @(negedge i_clk);
    checkBit("fair_first_ready0", o_m0_ready, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b1);
    granted = 1'b0;
    slot    = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_m1_ready) begin
        granted = 1'b1;
        slot    = (c + 1) / 2;
        break;
      end
      nextCycle();
    end
    checkBit("fair_m1_granted", granted, 1'b1);
    checkBit("fair_m1_slot_le2", (slot >= 1) && (slot <= 2), 1'b1);
    if (granted) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0);
      @(negedge i_clk);
      checkOutput("fair_lsu_addr", o_lsu_addr, 32'h200);
      checkOutput("fair_lsu_wdata", o_lsu_wdata, 32'h77);
      nextCycle();
      @(negedge i_clk);
      checkBit("fair_rsp_valid1", o_m1_rsp_valid, 1'b1);
      checkOutput("fair_rdata1", o_m1_rsp_rdata, 32'h300);
    end

    applyStimulus(1'b0, 1'b0);
    nextCycle();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
